// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT sequencer: walks all stages of an in-place N-point FFT through one
// shared butterfly, issuing reads every other cycle and writing YA/YB back by tag.
module fft_stage_sequencer #(
  parameter int LOG_N  = 4,
  parameter int X_WDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [LOG_N-1:0]      rd_addr_a,
  output logic [LOG_N-1:0]      rd_addr_b,
  input  logic [2*X_WDTH-1:0]   rd_data_a,
  input  logic [2*X_WDTH-1:0]   rd_data_b,
  output logic [LOG_N-2:0]      tw_addr,
  input  logic [2*X_WDTH-1:0]   tw_data,
  output logic [2*X_WDTH-1:0]   bf_xa,
  output logic [2*X_WDTH-1:0]   bf_xb,
  output logic [2*X_WDTH-1:0]   bf_w,
  output logic                  bf_x_nd,
  output logic [2*LOG_N-1:0]    bf_m_in,
  input  logic [2*LOG_N-1:0]    bf_m_out,
  input  logic [2*X_WDTH-1:0]   bf_y,
  input  logic                  bf_y_nd,
  output logic                  wr_en,
  output logic [LOG_N-1:0]      wr_addr,
  output logic [2*X_WDTH-1:0]   wr_data
);
  localparam int CW = 2 * X_WDTH;
  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [SW-1:0]      s_q, s_d;
  logic [LOG_N-2:0]   k_q, k_d;
  logic [LOG_N-1:0]   inflight_q, inflight_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_vld_q, rd_vld_d;
  logic [LOG_N-1:0]   rd_addr_a_q, rd_addr_a_d;
  logic [LOG_N-1:0]   rd_addr_b_q, rd_addr_b_d;
  logic [LOG_N-2:0]   tw_addr_q, tw_addr_d;
  logic [CW-1:0]      bf_xa_q, bf_xa_d;
  logic [CW-1:0]      bf_xb_q, bf_xb_d;
  logic [CW-1:0]      bf_w_q, bf_w_d;
  logic               bf_x_nd_q, bf_x_nd_d;
  logic [2*LOG_N-1:0] bf_m_in_q, bf_m_in_d;
  logic               wr_en_q, wr_en_d;
  logic [LOG_N-1:0]   wr_addr_q, wr_addr_d;
  logic [CW-1:0]      wr_data_q, wr_data_d;
  logic               yb_pend_q, yb_pend_d;
  logic [LOG_N-1:0]   yb_addr_q, yb_addr_d;
  logic               wb_b_q, wb_b_d;

  // Butterfly pair addressing for (stage s, index k); a always has bit s clear.
  logic [LOG_N-1:0]   k_ext, h_w, hm1_w, j_w, a_w, b_w;
  logic [LOG_N-2:0]   tw_w;
  logic               last_k, last_s, accept_y, pipe_empty;

  always_comb begin
    k_ext  = LOG_N'(k_q);
    h_w    = LOG_N'(1) << s_q;
    hm1_w  = h_w - LOG_N'(1);
    j_w    = k_ext & hm1_w;
    a_w    = ((k_ext & ~hm1_w) << 1) | j_w;
    b_w    = a_w | h_w;
    tw_w   = (LOG_N-1)'(j_w << (SW'(LOG_N-1) - s_q));
    last_k = (k_q == {(LOG_N-1){1'b1}});
    last_s = (s_q == SW'(LOG_N-1));
  end

  // Stage may only advance once nothing is in the read pipe or the butterfly.
  assign accept_y   = (state_q == ISSUE) || (state_q == DRAIN);
  assign pipe_empty = !rd_en_q && !rd_vld_q && !bf_x_nd_q && !yb_pend_q &&
                      (inflight_q == '0);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    s_d         = s_q;
    k_d         = k_q;
    inflight_d  = inflight_q;
    rd_en_d     = 1'b0;
    rd_vld_d    = rd_en_q;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_addr_d   = tw_addr_q;
    bf_xa_d     = bf_xa_q;
    bf_xb_d     = bf_xb_q;
    bf_w_d      = bf_w_q;
    bf_x_nd_d   = 1'b0;
    bf_m_in_d   = bf_m_in_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    yb_pend_d   = 1'b0;
    yb_addr_d   = yb_addr_q;
    wb_b_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          s_d        = '0;
          k_d        = '0;
          phase_d    = 1'b0;
          inflight_d = '0;
        end
      end
      ISSUE: begin
        if (!phase_q) begin
          rd_en_d     = 1'b1;
          rd_addr_a_d = a_w;
          rd_addr_b_d = b_w;
          tw_addr_d   = tw_w;
          phase_d     = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_k) state_d = DRAIN;
          else        k_d     = k_q + (LOG_N-1)'(1);
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            k_d     = '0;
            phase_d = 1'b0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read addresses are still held the cycle data returns, so they double as the tag.
    if (rd_vld_q) begin
      bf_xa_d   = rd_data_a;
      bf_xb_d   = rd_data_b;
      bf_w_d    = tw_data;
      bf_m_in_d = {rd_addr_a_q, rd_addr_b_q};
      bf_x_nd_d = 1'b1;
    end

    if (accept_y) begin
      if (yb_pend_q) begin
        wr_en_d   = 1'b1;
        wr_addr_d = yb_addr_q;
        wr_data_d = bf_y;
        wb_b_d    = 1'b1;
      end else if (bf_y_nd) begin
        wr_en_d   = 1'b1;
        wr_addr_d = bf_m_out[2*LOG_N-1:LOG_N];
        wr_data_d = bf_y;
        yb_addr_d = bf_m_out[LOG_N-1:0];
        yb_pend_d = 1'b1;
      end
    end

    unique case ({bf_x_nd_q, wb_b_q})
      2'b10:   inflight_d = inflight_q + LOG_N'(1);
      2'b01:   inflight_d = inflight_q - LOG_N'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      s_q         <= '0;
      k_q         <= '0;
      inflight_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      bf_xa_q     <= '0;
      bf_xb_q     <= '0;
      bf_w_q      <= '0;
      bf_x_nd_q   <= 1'b0;
      bf_m_in_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      yb_pend_q   <= 1'b0;
      yb_addr_q   <= '0;
      wb_b_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      s_q         <= s_d;
      k_q         <= k_d;
      inflight_q  <= inflight_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      bf_xa_q     <= bf_xa_d;
      bf_xb_q     <= bf_xb_d;
      bf_w_q      <= bf_w_d;
      bf_x_nd_q   <= bf_x_nd_d;
      bf_m_in_q   <= bf_m_in_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      yb_pend_q   <= yb_pend_d;
      yb_addr_q   <= yb_addr_d;
      wb_b_q      <= wb_b_d;
    end
  end

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign bf_xa     = bf_xa_q;
  assign bf_xb     = bf_xb_q;
  assign bf_w      = bf_w_q;
  assign bf_x_nd   = bf_x_nd_q;
  assign bf_m_in   = bf_m_in_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: RAM/ROM/butterfly models with random latency, DFT reference.
module tb_fft_stage_sequencer;
  localparam int LOG_N = 4;
  localparam int N     = 1 << LOG_N;
  localparam int CW    = 32;
  localparam real PI   = 3.14159265358979;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic              busy, done, rd_en, bf_x_nd, wr_en;
  logic [LOG_N-1:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [LOG_N-2:0]  tw_addr;
  logic [CW-1:0]     rd_data_a = '0, rd_data_b = '0, tw_data = '0, bf_y = '0;
  logic [CW-1:0]     bf_xa, bf_xb, bf_w, wr_data;
  logic [2*LOG_N-1:0] bf_m_in, bf_m_out = '0;
  logic              bf_y_nd = 1'b0;

  fft_stage_sequencer #(.LOG_N(LOG_N), .X_WDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .tw_addr(tw_addr), .tw_data(tw_data),
    .bf_xa(bf_xa), .bf_xb(bf_xb), .bf_w(bf_w), .bf_x_nd(bf_x_nd),
    .bf_m_in(bf_m_in), .bf_m_out(bf_m_out), .bf_y(bf_y), .bf_y_nd(bf_y_nd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc = cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [CW-1:0] mem [N];
  logic [CW-1:0] rom [N/2];
  int xin_re [N], xin_im [N];
  real exp_re [N], exp_im [N];

  function automatic logic [CW-1:0] pack(input int re, input int im);
    logic [CW-1:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction
  function automatic int re_of(input logic [CW-1:0] v); return int'($signed(v[31:16])); endfunction
  function automatic int im_of(input logic [CW-1:0] v); return int'($signed(v[15:0]));  endfunction
  function automatic int bitrev(input int i);
    int r = 0;
    for (int b = 0; b < LOG_N; b++) r = r | (((i >> b) & 1) << (LOG_N - 1 - b));
    return r;
  endfunction

  // RAM (registered read) and ROM models
  initial forever @(negedge clk) begin
    if (rd_en) begin rd_data_a = mem[rd_addr_a]; rd_data_b = mem[rd_addr_b]; end
    tw_data = rom[tw_addr];
    if (wr_en) mem[wr_addr] = wr_data;
  end

  // Butterfly model: Y = (XA +/- W*XB)/2, W in Q14, random latency, tag carried.
  typedef struct { int t; logic [CW-1:0] ya; logic [CW-1:0] yb; logic [2*LOG_N-1:0] tag; } bf_t;
  bf_t bq[$];
  bit inj_req = 0;
  initial begin
    bf_t e;
    int last_t = 0, pr, pi;
    bit yb_next = 0;
    logic [CW-1:0] yb_hold = '0;
    forever @(negedge clk) begin
      if (!rst_n) begin
        bq.delete(); yb_next = 0; bf_y_nd = 0;
      end else begin
        bf_y_nd = 0;
        if (yb_next) begin
          bf_y = yb_hold; yb_next = 0;
        end else if (inj_req) begin
          bf_y_nd = 1; bf_y = 32'h1234_5678; bf_m_out = 8'h5A;
          yb_hold = 32'h0BAD_0BAD; yb_next = 1; inj_req = 0;
        end else if (bq.size() > 0 && bq[0].t <= cyc) begin
          e = bq.pop_front();
          bf_y_nd = 1; bf_y = e.ya; bf_m_out = e.tag; yb_hold = e.yb; yb_next = 1;
        end
        if (bf_x_nd) begin
          pr = (re_of(bf_w) * re_of(bf_xb) - im_of(bf_w) * im_of(bf_xb)) >>> 14;
          pi = (re_of(bf_w) * im_of(bf_xb) + im_of(bf_w) * re_of(bf_xb)) >>> 14;
          e.ya  = pack((re_of(bf_xa) + pr) >>> 1, (im_of(bf_xa) + pi) >>> 1);
          e.yb  = pack((re_of(bf_xa) - pr) >>> 1, (im_of(bf_xa) - pi) >>> 1);
          e.tag = bf_m_in;
          e.t   = cyc + int'($urandom_range(2, 7));
          if (e.t < last_t + 2) e.t = last_t + 2;
          last_t = e.t;
          bq.push_back(e);
        end
      end
    end
  end

  // Event monitor
  int rd_cyc[$], nd_cyc[$];
  logic [LOG_N-1:0] rd_a[$], rd_b[$];
  logic [LOG_N-2:0] rd_tw[$];
  logic [2*LOG_N-1:0] nd_tag[$];
  int wr_cnt = 0, done_cnt = 0, b2b_cnt = 0, busy_done_cnt = 0;
  bit prev_nd = 0, busy_after_start = 0;
  initial forever @(negedge clk) begin
    if (rd_en) begin rd_cyc.push_back(cyc); rd_a.push_back(rd_addr_a); rd_b.push_back(rd_addr_b); rd_tw.push_back(tw_addr); end
    if (bf_x_nd) begin nd_cyc.push_back(cyc); nd_tag.push_back(bf_m_in); if (prev_nd) b2b_cnt++; end
    prev_nd = bf_x_nd;
    if (wr_en) wr_cnt++;
    if (done) begin done_cnt++; if (busy) busy_done_cnt++; end
  end

  initial begin #600000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  task automatic clear_log;
    rd_cyc.delete(); nd_cyc.delete(); rd_a.delete(); rd_b.delete(); rd_tw.delete(); nd_tag.delete();
    wr_cnt = 0; done_cnt = 0; b2b_cnt = 0; busy_done_cnt = 0;
  endtask

  task automatic load_mem;
    for (int i = 0; i < N; i++) mem[bitrev(i)] = pack(xin_re[i], xin_im[i]);
  endtask

  task automatic set_impulse;
    for (int i = 0; i < N; i++) begin xin_re[i] = (i == 0) ? 16384 : 0; xin_im[i] = 0; end
  endtask

  // Reference: X[k] = (1/N) * sum x[n] e^{-j2pi kn/N}
  task automatic ref_dft;
    real sr, si, ang;
    for (int k = 0; k < N; k++) begin
      sr = 0.0; si = 0.0;
      for (int n = 0; n < N; n++) begin
        ang = 2.0 * PI * real'(k * n) / real'(N);
        sr += real'(xin_re[n]) * $cos(ang) + real'(xin_im[n]) * $sin(ang);
        si += real'(xin_im[n]) * $cos(ang) - real'(xin_re[n]) * $sin(ang);
      end
      exp_re[k] = sr / real'(N); exp_im[k] = si / real'(N);
    end
  endtask

  int bad_k; real bad_got, bad_exp;
  function automatic int count_bad(input real tol);
    int bad = 0; real d;
    for (int k = 0; k < N; k++) begin
      for (int p = 0; p < 2; p++) begin
        d = (p == 0) ? real'(re_of(mem[k])) - exp_re[k] : real'(im_of(mem[k])) - exp_im[k];
        if (d < 0.0) d = -d;
        if (d > tol + 0.001) begin
          if (bad == 0) begin
            bad_k = k;
            bad_got = (p == 0) ? real'(re_of(mem[k])) : real'(im_of(mem[k]));
            bad_exp = (p == 0) ? exp_re[k] : exp_im[k];
          end
          bad++;
        end
      end
    end
    return bad;
  endfunction

  task automatic run_fft(output bit ok);
    ok = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; busy_after_start = busy;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL run_fft_timeout: no done within 3000 cycles"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, rd_en, wr_en, bf_x_nd} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 00000", {busy, done, rd_en, wr_en, bf_x_nd});
    end
    n_tests++;
    if ({rd_addr_a, rd_addr_b, tw_addr, wr_addr, bf_m_in, wr_data, bf_xa, bf_xb, bf_w} !== '0) begin
      n_fail++; $display("FAIL reset_data: address/data outputs not zero (wr_data=%h bf_m_in=%h)", wr_data, bf_m_in);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_impulse;
    bit ok; int errs;
    set_impulse(); load_mem(); ref_dft(); clear_log();
    run_fft(ok);
    n_tests++;
    if (busy_after_start !== 1'b1) begin n_fail++; $display("FAIL imp_busy_start: got %b required 1", busy_after_start); end
    n_tests++;
    if (rd_cyc.size() !== 32) begin n_fail++; $display("FAIL imp_rd_count: got %0d required 32", rd_cyc.size()); end
    errs = 0;
    for (int i = 1; i < rd_cyc.size(); i++) if (i % 8 != 0 && rd_cyc[i] - rd_cyc[i-1] != 2) errs++;
    n_tests++;
    if (errs !== 0) begin n_fail++; $display("FAIL imp_rd_spacing: %0d gaps not equal to 2, required 0", errs); end
    n_tests++;
    if (b2b_cnt !== 0) begin n_fail++; $display("FAIL imp_nd_b2b: got %0d back-to-back bf_x_nd, required 0", b2b_cnt); end
    errs = 0;
    for (int i = 0; i < rd_cyc.size(); i++)
      if (i >= nd_cyc.size() || nd_cyc[i] != rd_cyc[i] + 2 || nd_tag[i] !== {rd_a[i], rd_b[i]}) errs++;
    n_tests++;
    if (errs !== 0 || nd_cyc.size() !== rd_cyc.size()) begin
      n_fail++; $display("FAIL imp_nd_timing: %0d bad strobes, nd=%0d rd=%0d", errs, nd_cyc.size(), rd_cyc.size());
    end
    n_tests++;
    if (wr_cnt !== 64) begin n_fail++; $display("FAIL imp_wr_count: got %0d required 64", wr_cnt); end
    n_tests++;
    if (done_cnt !== 1 || busy_done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL imp_done: done_cnt=%0d busy_with_done=%0d busy=%b required 1/0/0", done_cnt, busy_done_cnt, busy);
    end
    n_tests++;
    if (count_bad(0.0) !== 0) begin
      n_fail++; $display("FAIL imp_bins: bin %0d got %0f required %0f", bad_k, bad_got, bad_exp);
    end
  endtask

  // Expected pairs: every a with bit s clear, ascending; twiddle exponent (a mod h)*N/(2h).
  task automatic test_addr_seq;
    int idx = 0, errs, h;
    for (int s = 0; s < LOG_N; s++) begin
      h = 1 << s; errs = 0;
      for (int a = 0; a < N; a++) begin
        if ((a & h) == 0) begin
          if (idx >= rd_cyc.size() || int'(rd_a[idx]) != a || int'(rd_b[idx]) != a + h ||
              int'(rd_tw[idx]) != (a % h) * (N / (2 * h))) errs++;
          idx++;
        end
      end
      n_tests++;
      if (errs !== 0) begin n_fail++; $display("FAIL addr_seq_stage%0d: %0d wrong pairs, required 0", s, errs); end
    end
  endtask

  task automatic test_dc;
    bit ok;
    for (int i = 0; i < N; i++) begin xin_re[i] = 16384; xin_im[i] = 0; end
    load_mem(); ref_dft(); clear_log();
    run_fft(ok);
    n_tests++;
    if (count_bad(2.0) !== 0) begin
      n_fail++; $display("FAIL dc_bins: bin %0d got %0f required %0f", bad_k, bad_got, bad_exp);
    end
    n_tests++;
    if (re_of(mem[0]) !== 16384) begin n_fail++; $display("FAIL dc_bin0: got %0d required 16384", re_of(mem[0])); end
  endtask

  task automatic test_random;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        xin_re[i] = int'($urandom_range(0, 16000)) - 8000;
        xin_im[i] = int'($urandom_range(0, 16000)) - 8000;
      end
      load_mem(); ref_dft(); clear_log();
      run_fft(ok);
      n_tests++;
      if (count_bad(4.0) !== 0) begin
        n_fail++; $display("FAIL rand%0d_bins: bin %0d got %0f required %0f", r, bad_k, bad_got, bad_exp);
      end
      n_tests++;
      if (wr_cnt !== 64 || done_cnt !== 1) begin
        n_fail++; $display("FAIL rand%0d_counts: writes=%0d done=%0d required 64/1", r, wr_cnt, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok = 0; int wr_snap, rd_snap;
    set_impulse(); load_mem(); clear_log();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rd_cyc.size() >= 20) begin ok = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_reach_stage2: got %0d reads, required 20", rd_cyc.size()); end
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    n_tests++;
    if ({busy, done, rd_en, wr_en, bf_x_nd} !== 5'b0) begin
      n_fail++; $display("FAIL rstmid_strobes: got %b required 00000", {busy, done, rd_en, wr_en, bf_x_nd});
    end
    wr_snap = wr_cnt; rd_snap = rd_cyc.size();
    repeat (20) @(negedge clk);
    n_tests++;
    if (wr_cnt !== wr_snap || rd_cyc.size() !== rd_snap || busy !== 1'b0 || done_cnt !== 0) begin
      n_fail++; $display("FAIL rstmid_idle: writes %0d->%0d reads %0d->%0d busy=%b done=%0d required unchanged/0/0",
                         wr_snap, wr_cnt, rd_snap, rd_cyc.size(), busy, done_cnt);
    end
    set_impulse(); load_mem(); ref_dft(); clear_log();
    run_fft(ok);
    n_tests++;
    if (count_bad(0.0) !== 0 || wr_cnt !== 64) begin
      n_fail++; $display("FAIL rstmid_rerun: bin %0d got %0f required %0f writes=%0d", bad_k, bad_got, bad_exp, wr_cnt);
    end
  endtask

  task automatic test_ignored;
    bit ok = 0;
    set_impulse(); load_mem(); ref_dft(); clear_log();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1; break; end
      start = (c % 23 == 5);
      @(negedge clk);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ign_timeout: no done within 3000 cycles"); end
    start = 1;
    @(negedge clk); start = 0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_start_at_done: busy=%b required 0", busy); end
    repeat (10) @(negedge clk);
    n_tests++;
    if (rd_cyc.size() !== 32 || done_cnt !== 1) begin
      n_fail++; $display("FAIL ign_start_busy: reads=%0d done=%0d required 32/1", rd_cyc.size(), done_cnt);
    end
    inj_req = 1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (wr_cnt !== 64 || busy !== 1'b0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL ign_idle_y_nd: writes=%0d busy=%b done=%0d required 64/0/1", wr_cnt, busy, done_cnt);
    end
    n_tests++;
    if (count_bad(0.0) !== 0) begin
      n_fail++; $display("FAIL ign_bins: bin %0d got %0f required %0f", bad_k, bad_got, bad_exp);
    end
  endtask

  initial begin
    real ang;
    for (int k = 0; k < N/2; k++) begin
      ang = 2.0 * PI * real'(k) / real'(N);
      rom[k] = pack($rtoi($floor(16384.0 * $cos(ang) + 0.5)), $rtoi($floor(-16384.0 * $sin(ang) + 0.5)));
    end
    for (int i = 0; i < N; i++) mem[i] = '0;
    test_reset();
    test_impulse();
    test_addr_seq();
    test_dc();
    test_random();
    test_reset_mid();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Controller that runs a complete in-place radix-2 DIT FFT of N = 2^LOG_N points through one shared butterfly instance.
- Per stage, it generates data-memory read addresses, the twiddle ROM address and butterfly input strobes, then writes YA/YB back to memory.
- Sits between a three-port sample RAM (2 read, 1 write; input already bit-reversed), a twiddle ROM (N/2 entries, W^k = exp(-j2πk/N)) and the butterfly.
- Butterfly rate limit is honoured: bf_x_nd is never high two cycles in a row.

Parameters:
- LOG_N, 4, log2 of FFT length; N = 1<<LOG_N.
- X_WDTH, 16, width of each real/imag part; complex words are 2*X_WDTH, {re,im}.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  one-cycle request to begin an FFT; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write of the last stage.
- rd_en  out  1  read strobe; rd_data_a/rd_data_b valid the following cycle.
- rd_addr_a  out  LOG_N  XA address.
- rd_addr_b  out  LOG_N  XB address.
- rd_data_a  in  2*X_WDTH  XA data.
- rd_data_b  in  2*X_WDTH  XB data.
- tw_addr  out  LOG_N-1  twiddle ROM address; tw_data valid the following cycle.
- tw_data  in  2*X_WDTH  twiddle W.
- bf_xa, bf_xb, bf_w  out  2*X_WDTH  butterfly operands (registered).
- bf_x_nd  out  1  butterfly new-data strobe.
- bf_m_in  out  2*LOG_N  {addr_a, addr_b} tag carried through the butterfly.
- bf_m_out  in  2*LOG_N  delayed tag.
- bf_y  in  2*X_WDTH  butterfly result.
- bf_y_nd  in  1  high when bf_y is YA; YB follows on the next cycle.
- wr_en  out  1  memory write strobe.
- wr_addr  out  LOG_N  write address.
- wr_data  out  2*X_WDTH  write data.

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start -> ISSUE, with stage s=0, butterfly index k=0 and inflight=0.
  - ISSUE: issue one butterfly every 2 cycles. Even phase: rd_en=1. Odd phase: the pipeline register captures data and asserts bf_x_nd. After k = N/2-1 is issued -> DRAIN.
  - DRAIN: wait until inflight==0. If s<LOG_N-1: s++, k=0 -> ISSUE. Otherwise -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Addressing for stage s, with h = 1<<s:
  - j = k & (h-1).
  - a = ((k>>s) << (s+1)) | j.
  - b = a + h.
  - tw_addr = j << (LOG_N-1-s).
- bf_x_nd asserts exactly 2 cycles after the corresponding rd_en, with bf_m_in={a,b}.
- bf_x_nd is never high on consecutive cycles; the gap is ≥1 cycle.
- Write-back:
  - On bf_y_nd=1: wr_en=1, wr_addr=bf_m_out[2*LOG_N-1:LOG_N], wr_data=bf_y. Latch bf_m_out[LOG_N-1:0].
  - Next cycle: wr_en=1, wr_addr=latched b, wr_data=bf_y (YB).
  - Write outputs are registered, so writes trail bf_y by 1 cycle.
- No fixed butterfly latency is assumed; only bf_y_nd/bf_m_out are used.
- inflight counter (width LOG_N): +1 on bf_x_nd, -1 on a YB write. If both happen in the same cycle, the value is unchanged.
- The next stage never reads before all writes of the current stage complete (DRAIN). Within a stage, addresses are disjoint, so no hazard exists.
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, bf_x_nd=0, all address/data outputs 0, state=IDLE.
- Reset mid-operation: return to IDLE next cycle and clear counters. The butterfly shares rst_n; any late bf_y_nd after reset is ignored until the next accepted start.
- start while busy: ignored, no effect.
- start in the same cycle as DONE: ignored.
- bf_y_nd while in IDLE: ignored, no write.
- Scaling: the butterfly halves each stage; the controller does no arithmetic on data.

Test Plan:
- Timing check (N=16, free-running ideal RAM/ROM model):
  - rd_en pulses exactly every 2 cycles, 8 per stage.
  - bf_x_nd is never back-to-back.
  - 64 total writes; done pulses once; busy drops with done.
- Address sequence: stage 0 pairs (0,1),(2,3)…, tw=0. Stage 3 pairs (0,8),(1,9)…(7,15), tw=0..7.
- Impulse: x[0]=16384+0j, others 0 -> all 16 bins re=1024, im=0.
- DC: all x=16384+0j -> bin0 re=16384; bins 1..15 within ±2 LSB of 0.
- Reset mid-FFT: assert rst_n=0 for 1 cycle during stage 2 -> next cycle all strobes 0, IDLE. A new start completes a correct impulse FFT.
- start pulses during busy, and bf_y_nd injected in IDLE -> no state change, no extra writes, exactly one done.
